// File: rtl/i2c_target_pkg.sv
// ----------------------------------------------------------------------------
// i2c_target_pkg
// Shared types and constants for the I2C target register controller.
//   ADDR_W_DEF : default register address width (16-byte register file)
//   state_e    : I2C transaction state (IDLE / PTR / DATA)
//   grant_e    : arbiter grant owner (I2C side / host side)
// ----------------------------------------------------------------------------
package i2c_target_pkg;

   localparam int ADDR_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PTR  = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   typedef enum logic {
      GNT_I2C  = 1'b0,
      GNT_HOST = 1'b1
   } grant_e;

endpackage

// File: rtl/i2c_reg_arbiter.sv
// ----------------------------------------------------------------------------
// i2c_reg_arbiter
// Two-requester round-robin arbiter for the single register-file port.
// The last winner is registered; on a tie the other requester wins. After
// reset the last winner is the host, so the I2C side takes the first tie.
//   CLK, RESET_n       : clock, async active-low reset
//   req_i2c, req_host  : requests (I2C write/prefetch, local host)
//   gnt_i2c, gnt_host  : one-hot (or zero) combinational grants
// ----------------------------------------------------------------------------
module i2c_reg_arbiter
   import i2c_target_pkg::*;
(
   input  logic CLK,
   input  logic RESET_n,
   input  logic req_i2c,
   input  logic req_host,
   output logic gnt_i2c,
   output logic gnt_host
);

   grant_e last_q;

   always_comb begin
      gnt_i2c  = req_i2c && (!req_host || (last_q == GNT_HOST));
      gnt_host = req_host && !gnt_i2c;
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n)      last_q <= GNT_HOST;
      else if (gnt_i2c)  last_q <= GNT_I2C;
      else if (gnt_host) last_q <= GNT_HOST;
   end

endmodule

// File: rtl/i2c_target_reg_ctrl.sv
// ----------------------------------------------------------------------------
// i2c_target_reg_ctrl
// Register-file back end for an I2C target. The first byte after an address
// match sets the register pointer, later bytes are written through a
// one-entry write buffer. Reads are served from a one-entry prefetch buffer.
// A local host shares the single register-file port via round-robin.
//
// Optional feature: define I2C_TARGET_AUTOINC_EN to advance the pointer after
// every I2C write commit and every accepted ACC_RD. Without it the pointer
// only changes on the pointer byte.
//
// Ports:
//   CLK, RESET_n            : clock, async active-low reset
//   ACC_START               : address-match pulse, restarts the transaction
//   ACC_WR / ACC_WDATA      : received byte strobe and data
//   ACC_RD                  : I2C IF consumed ACC_RDATA
//   ACC_RDATA / FIFO_EMPTY  : prefetched byte and its (inverted) valid
//   FIFO_FULL               : write buffer occupied
//   HOST_REQ/WE/ADDR/WDATA  : host access request, held until HOST_GNT
//   HOST_GNT / HOST_RDATA   : completion pulse and read data
// ----------------------------------------------------------------------------
module i2c_target_reg_ctrl
   import i2c_target_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
)(
   input  logic              CLK,
   input  logic              RESET_n,
   input  logic              ACC_START,
   input  logic              ACC_WR,
   input  logic [7:0]        ACC_WDATA,
   input  logic              ACC_RD,
   output logic [7:0]        ACC_RDATA,
   output logic              FIFO_EMPTY,
   output logic              FIFO_FULL,
   input  logic              HOST_REQ,
   input  logic              HOST_WE,
   input  logic [ADDR_W-1:0] HOST_ADDR,
   input  logic [7:0]        HOST_WDATA,
   output logic              HOST_GNT,
   output logic [7:0]        HOST_RDATA
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][7:0] regs_q;

   state_e            state_q, state_d;
   logic              ptr_load, wbuf_load;
   logic [ADDR_W-1:0] ptr_q;
   logic              ptr_vld_q;

   logic              wbuf_vld_q;
   logic [7:0]        wbuf_data_q;
   logic [ADDR_W-1:0] wbuf_addr_q;

   logic              rbuf_vld_q;
   logic [7:0]        rbuf_data_q;
   logic [ADDR_W-1:0] rbuf_addr_q;

   logic              host_gnt_q;
   logic [7:0]        host_rdata_q;

   logic              pf_req, i2c_req, host_req;
   logic              gnt_i2c, gnt_host;
   logic              wr_commit, pf_gnt, host_wr, host_rd;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [7:0]        wr_data, rd_data;
   logic              rd_accept, rbuf_inval;

   // ---------------- transaction FSM ----------------
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // ACC_START overrides everything, including a coincident ACC_WR.
   always_comb begin
      state_d   = state_q;
      ptr_load  = 1'b0;
      wbuf_load = 1'b0;
      if (ACC_START) begin
         state_d = ST_PTR;
      end else begin
         case (state_q)
            ST_PTR: begin
               if (ACC_WR) begin
                  ptr_load = 1'b1;
                  state_d  = ST_DATA;
               end
            end
            ST_DATA: begin
               // a byte arriving while the buffer is still full is dropped
               if (ACC_WR && !wbuf_vld_q) wbuf_load = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ---------------- arbitration ----------------
   // Prefetch waits for a pending write so it never returns pre-write data.
   assign pf_req   = !rbuf_vld_q && !wbuf_vld_q &&
                     ((state_q != ST_IDLE) || ptr_vld_q);
   assign i2c_req  = wbuf_vld_q || pf_req;
   // Host still holds REQ during its GNT cycle; do not grant it twice.
   assign host_req = HOST_REQ && !host_gnt_q;

   i2c_reg_arbiter u_arb (
      .CLK      (CLK),
      .RESET_n  (RESET_n),
      .req_i2c  (i2c_req),
      .req_host (host_req),
      .gnt_i2c  (gnt_i2c),
      .gnt_host (gnt_host)
   );

   assign wr_commit = gnt_i2c && wbuf_vld_q;
   assign pf_gnt    = gnt_i2c && !wbuf_vld_q;
   assign host_wr   = gnt_host && HOST_WE;
   assign host_rd   = gnt_host && !HOST_WE;

   assign wr_en   = wr_commit || host_wr;
   assign wr_addr = wr_commit ? wbuf_addr_q : HOST_ADDR;
   assign wr_data = wr_commit ? wbuf_data_q : HOST_WDATA;
   assign rd_addr = pf_gnt ? ptr_q : HOST_ADDR;
   assign rd_data = regs_q[rd_addr];

   assign rd_accept  = ACC_RD && rbuf_vld_q;
   // Invalidation beats a same-cycle prefetch grant; that grant is wasted.
   assign rbuf_inval = ACC_START || ptr_load || rd_accept ||
                       (wr_en && rbuf_vld_q && (wr_addr == rbuf_addr_q));

   // ---------------- register file ----------------
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n)   regs_q          <= '0;
      else if (wr_en) regs_q[wr_addr] <= wr_data;
   end

   // ---------------- pointer ----------------
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         ptr_q     <= '0;
         ptr_vld_q <= 1'b0;
      end else if (ptr_load) begin
         ptr_q     <= ACC_WDATA[ADDR_W-1:0];
         ptr_vld_q <= 1'b1;
      end
`ifdef I2C_TARGET_AUTOINC_EN
      else begin
         // natural wrap at 2**ADDR_W-1 -> 0
         ptr_q <= ptr_q + ADDR_W'(wr_commit) + ADDR_W'(rd_accept);
      end
`endif
   end

   // ---------------- write buffer ----------------
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         wbuf_vld_q  <= 1'b0;
         wbuf_data_q <= '0;
         wbuf_addr_q <= '0;
      end else if (wbuf_load) begin
         wbuf_vld_q  <= 1'b1;
         wbuf_data_q <= ACC_WDATA;
         wbuf_addr_q <= ptr_q;
      end else if (wr_commit) begin
         wbuf_vld_q  <= 1'b0;
      end
   end

   // ---------------- read (prefetch) buffer ----------------
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         rbuf_vld_q  <= 1'b0;
         rbuf_data_q <= '0;
         rbuf_addr_q <= '0;
      end else if (rbuf_inval) begin
         rbuf_vld_q  <= 1'b0;
      end else if (pf_gnt) begin
         rbuf_vld_q  <= 1'b1;
         rbuf_data_q <= rd_data;
         rbuf_addr_q <= ptr_q;
      end
   end

   // ---------------- host response ----------------
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         host_gnt_q   <= 1'b0;
         host_rdata_q <= '0;
      end else begin
         host_gnt_q <= gnt_host;
         if (host_rd) host_rdata_q <= rd_data;
      end
   end

   assign ACC_RDATA  = rbuf_data_q;
   assign FIFO_EMPTY = !rbuf_vld_q;
   assign FIFO_FULL  = wbuf_vld_q;
   assign HOST_GNT   = host_gnt_q;
   assign HOST_RDATA = host_rdata_q;

endmodule

// File: tb/tb_i2c_target_reg_ctrl.sv
// ----------------------------------------------------------------------------
// tb_i2c_target_reg_ctrl
// Directed bench: a host-access vector table plus hand-written I2C sequences.
// Expected values depend on whether I2C_TARGET_AUTOINC_EN is defined.
// ----------------------------------------------------------------------------
module tb_i2c_target_reg_ctrl;

   logic       CLK = 1'b0;
   logic       RESET_n = 1'b0;
   logic       ACC_START = 1'b0, ACC_WR = 1'b0, ACC_RD = 1'b0;
   logic [7:0] ACC_WDATA = '0;
   logic [7:0] ACC_RDATA;
   logic       FIFO_EMPTY, FIFO_FULL;
   logic       HOST_REQ = 1'b0, HOST_WE = 1'b0;
   logic [3:0] HOST_ADDR = '0;
   logic [7:0] HOST_WDATA = '0;
   logic       HOST_GNT;
   logic [7:0] HOST_RDATA;

   int n_cmp = 0;
   int n_bad = 0;

   i2c_target_reg_ctrl #(.ADDR_W(4)) dut (
      .CLK(CLK), .RESET_n(RESET_n),
      .ACC_START(ACC_START), .ACC_WR(ACC_WR), .ACC_WDATA(ACC_WDATA),
      .ACC_RD(ACC_RD), .ACC_RDATA(ACC_RDATA),
      .FIFO_EMPTY(FIFO_EMPTY), .FIFO_FULL(FIFO_FULL),
      .HOST_REQ(HOST_REQ), .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR),
      .HOST_WDATA(HOST_WDATA), .HOST_GNT(HOST_GNT), .HOST_RDATA(HOST_RDATA)
   );

   always #10 CLK = ~CLK;

   typedef struct {
      logic       we;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp;
   } hvec_t;

   hvec_t tbl[9];

`ifdef I2C_TARGET_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic chk_reset_outs(input string p);
      chk({p, "_rdata"}, ACC_RDATA, 8'h00);
      chk({p, "_empty"}, FIFO_EMPTY, 1'b1);
      chk({p, "_full"},  FIFO_FULL, 1'b0);
      chk({p, "_gnt"},   HOST_GNT, 1'b0);
      chk({p, "_hrd"},   HOST_RDATA, 8'h00);
   endtask

   task automatic do_reset();
      ACC_START = 0; ACC_WR = 0; ACC_RD = 0; HOST_REQ = 0;
      RESET_n = 0;
      repeat (2) tick();
      RESET_n = 1;
      tick();
   endtask

   task automatic acc_start();
      ACC_START = 1; tick(); ACC_START = 0;
   endtask

   task automatic acc_wr(input logic [7:0] b);
      ACC_WDATA = b; ACC_WR = 1; tick(); ACC_WR = 0;
   endtask

   // Returns at the cycle HOST_GNT is visible, with HOST_REQ dropped.
   task automatic host_acc(input logic we, input logic [3:0] a, input logic [7:0] wd,
                           output logic [7:0] rd, output int lat);
      HOST_WE = we; HOST_ADDR = a; HOST_WDATA = wd; HOST_REQ = 1;
      lat = 0;
      while (lat < 20) begin
         tick(); lat++;
         if (HOST_GNT) break;
      end
      chk("host_gnt_seen", HOST_GNT, 1'b1);
      rd = HOST_RDATA;
      HOST_REQ = 0;
   endtask

   task automatic host_rd(input logic [3:0] a, input string name, input logic [7:0] exp);
      logic [7:0] rd; int lat;
      host_acc(1'b0, a, 8'h00, rd, lat);
      chk(name, rd, exp);
   endtask

   task automatic wait_full_clear();
      int n = 0;
      while (FIFO_FULL && n < 20) begin tick(); n++; end
      chk("full_clears", FIFO_FULL, 1'b0);
   endtask

   task automatic wait_not_empty();
      int n = 0;
      while (FIFO_EMPTY && n < 20) begin tick(); n++; end
      chk("prefetch_done", FIFO_EMPTY, 1'b0);
   endtask

   initial begin
      logic [7:0] rd;
      int lat;

      tbl[0] = '{1'b1, 4'd1,  8'h11, 8'h00};
      tbl[1] = '{1'b1, 4'd2,  8'h22, 8'h00};
      tbl[2] = '{1'b1, 4'd15, 8'hF0, 8'h00};
      tbl[3] = '{1'b0, 4'd1,  8'h00, 8'h11};
      tbl[4] = '{1'b0, 4'd2,  8'h00, 8'h22};
      tbl[5] = '{1'b0, 4'd15, 8'h00, 8'hF0};
      tbl[6] = '{1'b0, 4'd0,  8'h00, 8'h00};
      tbl[7] = '{1'b1, 4'd1,  8'h5C, 8'h00};
      tbl[8] = '{1'b0, 4'd1,  8'h00, 8'h5C};

      // reset values
      RESET_n = 0;
      tick(); tick();
      chk_reset_outs("rst");
      RESET_n = 1;
      tick();

      // host-only table: uncontended, GNT one cycle after request/grant
      for (int i = 0; i < 9; i++) begin
         host_acc(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, lat);
         chk($sformatf("tbl%0d_lat", i), lat, 1);
         if (!tbl[i].we) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp);
         tick();
         chk($sformatf("tbl%0d_gnt_pulse", i), HOST_GNT, 1'b0);
      end

      // pointer 2, two data bytes, FIFO_FULL one cycle per byte
      do_reset();
      acc_start();
      acc_wr(8'h02);
      acc_wr(8'hA5);
      chk("wr1_full_hi", FIFO_FULL, 1'b1);
      tick();
      chk("wr1_full_lo", FIFO_FULL, 1'b0);
      acc_wr(8'h5A);
      chk("wr2_full_hi", FIFO_FULL, 1'b1);
      tick();
      chk("wr2_full_lo", FIFO_FULL, 1'b0);
      host_rd(4'd2, "ai_reg2", AUTOINC ? 8'hA5 : 8'h5A);
      host_rd(4'd3, "ai_reg3", AUTOINC ? 8'h5A : 8'h00);

      // read back via prefetch buffer
      acc_start();
      acc_wr(8'h02);
      chk("rd_empty_after_ptr", FIFO_EMPTY, 1'b1);
      tick();
      chk("rd_valid_next", FIFO_EMPTY, 1'b0);
      chk("rd_byte0", ACC_RDATA, AUTOINC ? 8'hA5 : 8'h5A);
      ACC_RD = 1;
      tick();                       // accepted
      chk("rd_consumed", FIFO_EMPTY, 1'b1);
      tick();                       // ACC_RD while empty: ignored
      ACC_RD = 0;
      chk("rd_refill", FIFO_EMPTY, 1'b0);
      chk("rd_byte1", ACC_RDATA, 8'h5A);

      // wrap at 0x0F, upper pointer bits ignored
      do_reset();
      acc_start();
      acc_wr(8'hFF);
      acc_wr(8'h11);
      wait_full_clear();
      acc_wr(8'h22);
      wait_full_clear();
      host_rd(4'd15, "wrap_reg15", AUTOINC ? 8'h11 : 8'h22);
      host_rd(4'd0,  "wrap_reg0",  AUTOINC ? 8'h22 : 8'h00);

      // fixed pointer 4
      do_reset();
      acc_start();
      acc_wr(8'h04);
      acc_wr(8'h10);
      wait_full_clear();
      acc_wr(8'h20);
      wait_full_clear();
      host_rd(4'd4, "fix_reg4", AUTOINC ? 8'h10 : 8'h20);
      host_rd(4'd5, "fix_reg5", AUTOINC ? 8'h20 : 8'h00);

      // back-to-back ACC_WR: second byte hits FIFO_FULL and is dropped
      do_reset();
      acc_start();
      acc_wr(8'h07);
      ACC_WDATA = 8'h44; ACC_WR = 1;
      tick();
      ACC_WDATA = 8'h55;
      tick();
      ACC_WR = 0;
      wait_full_clear();
      host_rd(4'd7, "drop_reg7", 8'h44);
      host_rd(4'd8, "drop_reg8", 8'h00);

      // I2C commit and host write to addr 3 contend
      do_reset();
      acc_start();
      acc_wr(8'h03);
      wait_not_empty();
      host_rd(4'd0, "arb_pre_rd", 8'h00);   // makes host the last winner
      acc_wr(8'h33);
      HOST_WE = 1; HOST_ADDR = 4'd3; HOST_WDATA = 8'h77; HOST_REQ = 1;
      chk("arb_wbuf_full", FIFO_FULL, 1'b1);
      tick();
      chk("arb_i2c_first", FIFO_FULL, 1'b0);
      chk("arb_no_gnt_yet", HOST_GNT, 1'b0);
      chk("arb_rbuf_inval", FIFO_EMPTY, 1'b1);
      tick();
      chk("arb_host_gnt", HOST_GNT, 1'b1);
      HOST_REQ = 0;
      tick();
      chk("arb_gnt_pulse", HOST_GNT, 1'b0);
      chk("arb_refill", FIFO_EMPTY, 1'b0);
      chk("arb_refill_data", ACC_RDATA, AUTOINC ? 8'h00 : 8'h77);
      host_rd(4'd3, "arb_reg3", 8'h77);

      // reset while a write is pending
      acc_start();
      acc_wr(8'h05);
      acc_wr(8'h99);
      chk("mid_full", FIFO_FULL, 1'b1);
      #4 RESET_n = 0;
      #1;
      chk_reset_outs("mid_rst");
      tick(); tick();
      RESET_n = 1;
      tick();
      host_rd(4'd5, "mid_reg5", 8'h00);
      host_rd(4'd3, "mid_reg3", 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_target_reg_ctrl.md
I2C_TARGET_REG_CTRL -- requirements
Module: i2c_target_reg_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 4, register address width; register file depth is 2**ADDR_W bytes.
REQ-002 SHALL have port: CLK  input  1  system clock (50 MHz); all logic on rising edge.
REQ-003 SHALL have port: RESET_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: ACC_START  input  1  one-CLK pulse from I2C target IF on address-match ACK.
REQ-005 SHALL have port: ACC_WR  input  1  one-CLK pulse; received byte on ACC_WDATA.
REQ-006 SHALL have port: ACC_WDATA  input  8  received I2C byte.
REQ-007 SHALL have port: ACC_RD  input  1  one-CLK pulse; IF consumed ACC_RDATA.
REQ-008 SHALL have port: ACC_RDATA  output  8  next byte to transmit.
REQ-009 SHALL have port: FIFO_EMPTY  output  1  ACC_RDATA not valid.
REQ-010 SHALL have port: FIFO_FULL  output  1  write buffer occupied.
REQ-011 SHALL have port: HOST_REQ  input  1  local host access request, held until HOST_GNT.
REQ-012 SHALL have port: HOST_WE  input  1  1=write, 0=read.
REQ-013 SHALL have port: HOST_ADDR  input  ADDR_W  host register address.
REQ-014 SHALL have port: HOST_WDATA  input  8  host write data.
REQ-015 SHALL have port: HOST_GNT  output  1  one-CLK pulse, access done.
REQ-016 SHALL have port: HOST_RDATA  output  8  read data, valid with HOST_GNT.

Function
REQ-017 SHALL hold a 2**ADDR_W x 8 flop register file, one access (read or write) per CLK.
REQ-018 SHALL implement states IDLE, PTR, DATA; ACC_START from any state -> PTR and invalidates read buffer.
REQ-019 In PTR, ACC_WR SHALL load pointer = ACC_WDATA[ADDR_W-1:0] (upper bits ignored), invalidate read buffer, -> DATA.
REQ-020 In DATA, ACC_WR SHALL load one-entry write buffer; FIFO_FULL=1 from next cycle until cycle after commit (exactly 1 cycle if uncontended).
REQ-021 ACC_WR while FIFO_FULL=1, or in IDLE, SHALL be dropped; ACC_START coincident with ACC_WR wins, byte dropped.
REQ-022 Read prefetch SHALL request regfile[pointer] whenever read buffer invalid, write buffer empty, state != IDLE or pointer valid since reset; FIFO_EMPTY=0 the cycle after grant.
REQ-023 ACC_RD with FIFO_EMPTY=0 SHALL invalidate buffer (FIFO_EMPTY=1 next cycle); ACC_RD with FIFO_EMPTY=1 ignored.
REQ-024 Any committed write (I2C or host) to the address held in read buffer SHALL invalidate it.
REQ-025 Arbiter SHALL round-robin between I2C side (write before prefetch) and host when both pending; last-grant resets to host, so I2C wins first tie.
REQ-026 Host access granted in cycle N SHALL pulse HOST_GNT (and HOST_RDATA for reads) in cycle N+1; host deasserts HOST_REQ in that cycle.
REQ-027 Pointer SHALL wrap 2**ADDR_W-1 -> 0.

Reset
REQ-028 RESET_n low SHALL force: state IDLE, pointer 0, all registers 0, buffers invalid, ACC_RDATA=0, FIFO_EMPTY=1, FIFO_FULL=0, HOST_GNT=0, HOST_RDATA=0, last-grant=host.
REQ-029 Reset mid-transaction SHALL discard pending write and prefetch without commit.

Configuration
REQ-030 With I2C_TARGET_AUTOINC_EN defined, pointer SHALL increment after each I2C write commit and each accepted ACC_RD.
REQ-031 Without I2C_TARGET_AUTOINC_EN, pointer SHALL change only in PTR state; repeated accesses hit same register.

Structure
REQ-032 Package i2c_target_pkg SHALL hold state enum, grant enum and ADDR_W default constant.
REQ-033 Round-robin arbitration SHALL be sub-module i2c_reg_arbiter (two requesters, registered last-grant).

Verification
REQ-034 AUTOINC: ACC_START, ACC_WR 0x02, 0xA5, 0x5A -> reg[2]=0xA5, reg[3]=0x5A, FIFO_FULL high 1 cycle per data byte.
REQ-035 Then ACC_START, ACC_WR 0x02 -> ACC_RDATA=0xA5 with FIFO_EMPTY=0; ACC_RD -> next ACC_RDATA=0x5A.
REQ-036 Pointer 0x0F, ACC_WR 0x11, 0x22 -> reg[15]=0x11, reg[0]=0x22 (wrap).
REQ-037 I2C commit 0x33 and host write 0x77 to addr 3 pending same cycle -> I2C first, host next, reg[3]=0x77, HOST_GNT one cycle after host grant, buffered read of addr 3 invalidated.
REQ-038 RESET_n low while FIFO_FULL=1 -> all outputs at reset values, reg[ptr] stays 0x00.
REQ-039 Macro undefined: pointer 0x04, ACC_WR 0x10, 0x20 -> reg[4]=0x20, reg[5]=0x00.
